// File: rtl/testdec_mux_pipe_if.sv
// Handshake/bus bundle for testdec_mux_pipe.
//   din       : flat input bus, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sel       : input index
//   in_valid  : din/sel valid          in_ready  : block accepts a beat
//   dout      : selected data          out_err   : beat had an out-of-range sel
//   out_valid : dout/out_err valid     out_ready : downstream accepts a beat
//   err_clr   : synchronous clear of err_cnt
//   err_cnt   : count of accepted out-of-range beats (saturating)
// master drives the upstream/downstream side, slave is the mux pipeline.
interface testdec_mux_pipe_if #(
  parameter int NUM_INPUTS = 14,
  parameter int DATA_WIDTH = 128
);
  localparam int SEL_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [NUM_INPUTS*DATA_WIDTH-1:0] din;
  logic [SEL_WIDTH-1:0]             sel;
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            dout;
  logic                             out_err;
  logic                             out_valid;
  logic                             out_ready;
  logic                             err_clr;
  logic [15:0]                      err_cnt;

  modport master (
    output din, sel, in_valid, out_ready, err_clr,
    input  in_ready, dout, out_err, out_valid, err_cnt
  );

  modport slave (
    input  din, sel, in_valid, out_ready, err_clr,
    output in_ready, dout, out_err, out_valid, err_cnt
  );
endinterface

// File: rtl/testdec_mux_pipe.sv
// Pipelined N:1 data mux with valid/ready handshake and out-of-range error
// counting. The full mux is resolved in front of stage 1; later stages are
// plain bubble-collapsing register slices, so dout/out_err/out_valid come
// straight from the last stage's flops.
//   ap_clk : clock, rising edge
//   ap_rst : asynchronous active-high reset
//   bus    : testdec_mux_pipe_if.slave (din/sel/in_valid/in_ready,
//            dout/out_err/out_valid/out_ready, err_clr/err_cnt)
module testdec_mux_pipe #(
  parameter int NUM_INPUTS = 14,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_STAGE  = 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  testdec_mux_pipe_if.slave    bus
);
  localparam int SEL_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [DATA_WIDTH-1:0] mux_data;
  logic                  mux_err;

  logic [NUM_STAGE-1:0]  stg_v;
  logic [NUM_STAGE-1:0]  stg_e;
  logic [DATA_WIDTH-1:0] stg_d [NUM_STAGE];
  logic [NUM_STAGE-1:0]  adv;
  logic                  hole;

  logic                  accept;
  logic                  accept_err;
  logic [15:0]           err_cnt_q;

  // Out-of-range selects fall through with zero data and the error flag set.
  always_comb begin
    mux_data = '0;
    mux_err  = 1'b1;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (bus.sel == SEL_WIDTH'(i)) begin
        mux_data = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
        mux_err  = 1'b0;
      end
    end
  end

  // A stage may advance when there is a free slot anywhere downstream of it
  // or the last stage is draining; computing it as an accumulated "hole seen"
  // flag from the output side keeps the chain free of combinational loops.
  always_comb begin
    hole = bus.out_ready;
    adv  = '0;
    for (int unsigned j = NUM_STAGE; j > 0; j--) begin
      hole     = hole || !stg_v[j-1];
      adv[j-1] = hole;
    end
  end

  assign accept     = bus.in_valid && adv[0];
  assign accept_err = accept && mux_err;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stg_v <= '0;
      stg_e <= '0;
      for (int unsigned k = 0; k < NUM_STAGE; k++) begin
        stg_d[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        stg_v[0] <= bus.in_valid;
        stg_d[0] <= mux_data;
        stg_e[0] <= mux_err;
      end
      for (int unsigned k = 1; k < NUM_STAGE; k++) begin
        if (adv[k]) begin
          stg_v[k] <= stg_v[k-1];
          stg_d[k] <= stg_d[k-1];
          stg_e[k] <= stg_e[k-1];
        end
      end
    end
  end

  // Clear takes effect before counting, so clear+error in one cycle yields 1.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      err_cnt_q <= '0;
    end else if (accept_err) begin
      if (bus.err_clr) begin
        err_cnt_q <= 16'd1;
      end else if (err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end else if (bus.err_clr) begin
      err_cnt_q <= '0;
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = stg_v[NUM_STAGE-1];
  assign bus.dout      = stg_d[NUM_STAGE-1];
  assign bus.out_err   = stg_e[NUM_STAGE-1];
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: doc/testdec_mux_pipe.md
TESTDEC_MUX_PIPE -- requirements
Module: testdec_mux_pipe

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 14: number of data inputs, legal range 2..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 128: width of each data input and of dout.
REQ-003 SHALL have parameter NUM_STAGE, default 2: pipeline depth in cycles, legal range 1..4.
REQ-004 SHALL have derived localparam SEL_WIDTH = clog2(NUM_INPUTS), minimum 1.
REQ-005 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port ap_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port din, input, NUM_INPUTS*DATA_WIDTH bits: flat input bus; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port sel, input, SEL_WIDTH bits: input index.
REQ-009 SHALL have port in_valid, input, 1 bit: din/sel valid.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-011 SHALL have port dout, output, DATA_WIDTH bits: selected data.
REQ-012 SHALL have port out_err, output, 1 bit: beat had an out-of-range sel.
REQ-013 SHALL have port out_valid, output, 1 bit: dout/out_err valid.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts a beat.
REQ-015 SHALL have port err_clr, input, 1 bit: synchronous clear of err_cnt.
REQ-016 SHALL have port err_cnt, output, 16 bits: count of accepted out-of-range beats.

Function
REQ-017 SHALL accept a beat on a rising edge where in_valid=1 and in_ready=1; beats are transferred out on a rising edge where out_valid=1 and out_ready=1.
REQ-018 SHALL contain NUM_STAGE register stages, each holding a valid bit, a DATA_WIDTH data field and an err bit; the mux tree may be split across stages in any way, provided the datapath is fully registered at stage NUM_STAGE.
REQ-019 SHALL advance stage k when its successor is empty or is itself advancing; the last stage advances when out_ready=1 or out_valid=0 (bubble-collapsing).
REQ-020 SHALL drive in_ready = (stage 1 empty) OR (stage 1 advancing); in_ready is combinational from out_ready and the stage valids only, never from in_valid.
REQ-021 SHALL, with out_ready held at 1, present a beat accepted in cycle c on dout with out_valid=1 in cycle c+NUM_STAGE, and sustain one beat per cycle.
REQ-022 SHALL present beats in acceptance order, with no drop and no duplication.
REQ-023 SHALL hold dout, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when sel < NUM_INPUTS, make dout equal to input sel and out_err=0.
REQ-025 SHALL, when sel >= NUM_INPUTS, make dout all-zero and out_err=1.
REQ-026 SHALL increment err_cnt by 1 on each accepted beat with sel >= NUM_INPUTS, saturating at 16'hFFFF.
REQ-027 SHALL, on a cycle where err_clr=1 and an out-of-range beat is accepted together, set err_cnt to 1 (clear, then count).
REQ-028 SHALL, on a cycle where err_clr=1 and no out-of-range beat is accepted, set err_cnt to 0.
REQ-029 SHALL make dout, out_valid and out_err purely registered outputs, with no combinational path from din or sel.

Reset
REQ-030 SHALL, while ap_rst=1, asynchronously force all stage valid bits to 0, all data and err fields to 0, and err_cnt to 0.
REQ-031 SHALL therefore hold out_valid=0, dout=0, out_err=0 and err_cnt=0 throughout reset.
REQ-032 SHALL drive in_ready=1 during reset (all stages empty) while ignoring in_valid.
REQ-033 SHALL discard in-flight beats on a reset asserted mid-operation, with none emitted after deassertion.
REQ-034 SHALL allow the first accepted beat on the first rising edge after ap_rst deasserts.

Verification
REQ-035 SHALL be covered by a bench scenario with NUM_INPUTS=14, NUM_STAGE=2, out_ready=1: stream sel=0..13 back-to-back, each input i = 128'h0..0_i -> dout sequence 0..13 starting 2 cycles after the first accept, out_valid continuous for 14 cycles, out_err=0.
REQ-036 SHALL be covered by a bench scenario that sends sel=14 then sel=15 -> dout=0 and out_err=1 for both beats, err_cnt=2; then err_clr=1 together with an accepted sel=15 -> err_cnt=1.
REQ-037 SHALL be covered by a bench scenario that fills the pipeline with out_ready=0 -> exactly NUM_STAGE beats accepted, then in_ready=0 and dout held stable; then out_ready=1 -> all beats drain in order with no loss.
REQ-038 SHALL be covered by a bench scenario that drives out_ready with a random 50% duty while in_valid=1 with random sel -> every output beat matches a scoreboard and in order.
REQ-039 SHALL be covered by a bench scenario that asserts ap_rst between clock edges with 2 beats in flight -> out_valid=0 and err_cnt=0 immediately, with no stale beat emitted after release.
REQ-040 SHALL be covered by a bench scenario that pre-sets err_cnt to 16'hFFFE via 2 extra out-of-range beats over a forced start value, or via long random injection -> err_cnt saturates at 16'hFFFF.
